// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Two-stage pipelined immediate generator sitting between the
//               instruction register and the ALU operand mux. Stage 1
//               captures the IMM_W immediate field and classifies the
//               extension mode. Stage 2 builds the DATA_W-wide immediate.
//               Both stages use valid/ready handshakes with full throughput,
//               and Flush discards everything in flight.
//
// Ports       : Clk, Reset       - clock, synchronous active-high reset
//               InValid/InReady  - input beat handshake (IROut, ALUOp)
//               IROut            - instruction word (DATA_W)
//               ALUOp            - decoded ALU opcode (6)
//               Flush            - synchronous discard of in-flight beats
//               OutValid/OutReady- output beat handshake (Imm, ImmMode)
//               Imm              - extended immediate (DATA_W)
//               ImmMode          - 00 zero, 01 sign, 10 branch, 11 upper
//               SignCount,
//               ZeroCount        - saturating output-mode counters, present
//                                  only when IMM_STATS_EN is defined
//
// Options     : `define IMM_STATS_EN adds SignCount/ZeroCount.
//
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int         DATA_W   = 32,
    parameter int         IMM_W    = 16,
    parameter int         BR_SHIFT = 0,
    parameter logic [5:0] LUI_OP   = 6'b111010
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] IROut,
    input  logic [5:0]        ALUOp,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] Imm,
    output logic [1:0]        ImmMode
`ifdef IMM_STATS_EN
    ,
    output logic [15:0]       SignCount,
    output logic [15:0]       ZeroCount
`endif
);

    localparam logic [1:0] c_MODE_ZERO   = 2'b00;
    localparam logic [1:0] c_MODE_SIGN   = 2'b01;
    localparam logic [1:0] c_MODE_BRANCH = 2'b10;
    localparam logic [1:0] c_MODE_UPPER  = 2'b11;

    localparam logic [5:0] c_OP_ADDI = 6'b110010;
    localparam logic [5:0] c_OP_SUBI = 6'b110011;
    localparam logic [5:0] c_OP_SLTI = 6'b110111;

    localparam int c_EXT_W = DATA_W - IMM_W;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [IMM_W-1:0]  r_s1_field;
    logic [1:0]        r_s1_mode;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_imm;
    logic [1:0]        r_mode;

    logic              w_s2_ready;
    logic              w_s1_moves;
    logic              w_accept;
    logic [1:0]        w_mode_in;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_imm_next;

    // Stage 2 can take new data when empty or when its beat leaves now.
    // InReady depends only on state and OutReady, never on InValid.
    assign w_s2_ready = !r_s2_valid || OutReady;
    assign w_s1_moves = r_s1_valid && w_s2_ready;
    assign InReady    = !r_s1_valid || w_s1_moves;
    assign w_accept   = InValid && InReady && !Flush;

    assign OutValid = r_s2_valid;
    assign Imm      = r_imm;
    assign ImmMode  = r_mode;

    // Mode classification; the branch pattern in the top two bits wins
    // over any opcode.
    always_comb begin
        w_mode_in = c_MODE_ZERO;
        if (IROut[DATA_W-1 -: 2] == 2'b10) begin
            w_mode_in = c_MODE_BRANCH;
        end else if (ALUOp == LUI_OP) begin
            w_mode_in = c_MODE_UPPER;
        end else if ((ALUOp == c_OP_ADDI) || (ALUOp == c_OP_SUBI) ||
                     (ALUOp == c_OP_SLTI)) begin
            w_mode_in = c_MODE_SIGN;
        end
    end

    assign w_sext = {{c_EXT_W{r_s1_field[IMM_W-1]}}, r_s1_field};

    always_comb begin
        w_imm_next = {{c_EXT_W{1'b0}}, r_s1_field};
        case (r_s1_mode)
            c_MODE_SIGN:   w_imm_next = w_sext;
            // Bits shifted past the MSB are simply dropped.
            c_MODE_BRANCH: w_imm_next = w_sext << BR_SHIFT;
            c_MODE_UPPER:  w_imm_next = {r_s1_field, {c_EXT_W{1'b0}}};
            default:       w_imm_next = {{c_EXT_W{1'b0}}, r_s1_field};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_field <= '0;
            r_s1_mode  <= c_MODE_ZERO;
            r_s2_valid <= 1'b0;
            r_imm      <= '0;
            r_mode     <= c_MODE_ZERO;
        end else if (Flush) begin
            // Data registers keep their contents; only the valids drop.
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (InReady) begin
                r_s1_valid <= InValid;
            end
            if (w_accept) begin
                r_s1_field <= IROut[IMM_W-1:0];
                r_s1_mode  <= w_mode_in;
            end
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            // Imm/ImmMode change only when a new beat enters stage 2, so
            // they hold steady while the consumer stalls.
            if (w_s1_moves) begin
                r_imm  <= w_imm_next;
                r_mode <= r_s1_mode;
            end
        end
    end

    // Instruction bits between the immediate field and the branch tag are
    // intentionally ignored.
    generate
        if (DATA_W > IMM_W + 2) begin : g_unused_bits
            logic w_unused_ir;
            assign w_unused_ir = ^IROut[DATA_W-3:IMM_W];
        end
    endgenerate

`ifdef IMM_STATS_EN
    logic        w_out_hs;
    logic        w_is_signed_mode;
    logic [15:0] r_sign_cnt;
    logic [15:0] r_zero_cnt;

    assign w_out_hs         = r_s2_valid && OutReady;
    // Modes 01 and 10 carry a sign extension; 00 and 11 do not.
    assign w_is_signed_mode = r_mode[1] ^ r_mode[0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sign_cnt <= '0;
            r_zero_cnt <= '0;
        end else if (w_out_hs) begin
            if (w_is_signed_mode) begin
                if (r_sign_cnt != 16'hFFFF) begin
                    r_sign_cnt <= r_sign_cnt + 16'd1;
                end
            end else begin
                if (r_zero_cnt != 16'hFFFF) begin
                    r_zero_cnt <= r_zero_cnt + 16'd1;
                end
            end
        end
    end

    assign SignCount = r_sign_cnt;
    assign ZeroCount = r_zero_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Self-checking bench for imm_extend_pipe (BR_SHIFT = 2).
//               Directed vectors, a backpressure stream, a flush scenario
//               and a randomized phase, all checked against a
//               transaction-level reference model (timestamped queue).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imm_extend_pipe;

    localparam int BR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir_out;
    logic [5:0]  alu_op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm;
    logic [1:0]  imm_mode;
`ifdef IMM_STATS_EN
    logic [15:0] sign_count;
    logic [15:0] zero_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: in-flight beats in order, with the cycle of accept.
    int          q_acc[$];
    logic [33:0] q_dat[$];
    int          cyc = 0;
    int          delivered = 0;
    int          m_sign = 0;
    int          m_zero = 0;

    imm_extend_pipe #(
        .DATA_W   (32),
        .IMM_W    (16),
        .BR_SHIFT (BR),
        .LUI_OP   (6'b111010)
    ) u_dut (
        .Clk      (clk),
        .Reset    (rst),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .IROut    (ir_out),
        .ALUOp    (alu_op),
        .Flush    (flush),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Imm      (imm),
        .ImmMode  (imm_mode)
`ifdef IMM_STATS_EN
        ,
        .SignCount(sign_count),
        .ZeroCount(zero_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected {mode, imm} computed with plain integer arithmetic.
    function automatic logic [33:0] ref_beat(input logic [31:0] ir, input logic [5:0] op);
        int          f;
        int          sv;
        logic [1:0]  m;
        logic [31:0] v;
        f  = int'(ir & 32'h0000_FFFF);
        sv = (f >= 32768) ? f - 65536 : f;
        if (ir[31:30] == 2'b10) begin
            m = 2'd2;
            v = 32'(sv * (1 << BR));
        end else if (op == 6'b111010) begin
            m = 2'd3;
            v = 32'(f * 65536);
        end else if (op == 6'd50 || op == 6'd51 || op == 6'd55) begin
            m = 2'd1;
            v = 32'(sv);
        end else begin
            m = 2'd0;
            v = 32'(f);
        end
        return {m, v};
    endfunction

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input logic iv, input logic [31:0] ir, input logic [5:0] op,
                        input logic ordy, input logic fl, input logic rs,
                        output logic accepted);
        logic        exp_ov;
        logic        exp_ir;
        logic [33:0] head;
        int          now;
        @(negedge clk);
        in_valid  = iv;
        ir_out    = ir;
        alu_op    = op;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        exp_ov = (q_acc.size() > 0) && (q_acc[0] <= cyc - 2);
        exp_ir = !(q_acc.size() == 2 && !ordy);
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov && out_valid) begin
            head = q_dat[0];
            chk("imm", imm, head[31:0]);
            chk("imm_mode", imm_mode, head[33:32]);
        end
`ifdef IMM_STATS_EN
        chk("sign_count", sign_count, m_sign);
        chk("zero_count", zero_count, m_zero);
`endif
        now      = cyc;
        accepted = 1'b0;
        @(posedge clk);
        cyc++;
        if (rs) begin
            q_acc.delete();
            q_dat.delete();
            m_sign = 0;
            m_zero = 0;
        end else begin
            if (exp_ov && ordy) begin
                head = q_dat.pop_front();
                void'(q_acc.pop_front());
                delivered++;
                if (head[33] ^ head[32]) begin
                    if (m_sign < 65535) m_sign++;
                end else begin
                    if (m_zero < 65535) m_zero++;
                end
            end
            if (fl) begin
                q_acc.delete();
                q_dat.delete();
            end else if (iv && exp_ir) begin
                q_acc.push_back(now);
                q_dat.push_back(ref_beat(ir, op));
                accepted = 1'b1;
            end
        end
    endtask

    // Single beat with OutReady high; checks literal results at latency 2.
    task automatic directed(input logic [31:0] ir, input logic [5:0] op,
                            input logic [31:0] exp_imm, input logic [1:0] exp_mode);
        logic a;
        step(1'b1, ir, op, 1'b1, 1'b0, 1'b0, a);
        chk("dir_accept", a, 1'b1);
        step(1'b0, 32'h0, 6'h0, 1'b1, 1'b0, 1'b0, a);
        #2;
        chk("dir_out_valid", out_valid, 1'b1);
        chk("dir_imm", imm, exp_imm);
        chk("dir_mode", imm_mode, exp_mode);
        step(1'b0, 32'h0, 6'h0, 1'b1, 1'b0, 1'b0, a);
    endtask

    initial begin
        logic        a;
        int          k;
        int          d0;
        logic [31:0] rir;
        logic [5:0]  rop;

        rst = 1'b1; in_valid = 1'b0; ir_out = '0; alu_op = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_imm", imm, 32'h0);
        chk("rst_mode", imm_mode, 2'b00);

        // Directed vectors
        directed(32'h0000_8001, 6'b110010, 32'hFFFF_8001, 2'b01);
        directed(32'h0000_8001, 6'b000000, 32'h0000_8001, 2'b00);
        directed(32'h0000_8001, 6'b111010, 32'h8001_0000, 2'b11);
        directed(32'h8000_FFFE, 6'b110010, 32'hFFFF_FFF8, 2'b10);
        directed(32'h0000_7FFF, 6'b110111, 32'h0000_7FFF, 2'b01);
        directed(32'hC000_0001, 6'b110011, 32'h0000_0001, 2'b01);
        directed(32'h8000_4000, 6'b111010, 32'h0001_0000, 2'b10);

        // Four-beat stream with consumer stalled for cycles 3..6
        k  = 0;
        d0 = delivered;
        for (int i = 1; i <= 14; i++) begin
            step(k < 4, 32'h0000_0100 * (k + 1), (k % 2 == 0) ? 6'b110010 : 6'b000001,
                 !(i >= 3 && i <= 6), 1'b0, 1'b0, a);
            if (a) k++;
        end
        chk("stream_sent", k, 4);
        chk("stream_delivered", delivered - d0, 4);

        // Fill pipeline, then flush while offering another beat
        step(1'b1, 32'h0000_1111, 6'b110010, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h0000_2222, 6'b110010, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h0000_3333, 6'b110010, 1'b0, 1'b0, 1'b0, a);
        d0 = delivered;
        step(1'b1, 32'h0000_4444, 6'b110010, 1'b0, 1'b1, 1'b0, a);
        #2;
        chk("flush_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 6'h0, 1'b1, 1'b0, 1'b0, a);
        chk("flush_nothing_delivered", delivered - d0, 0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            rir = $urandom;
            case ($urandom_range(0, 4))
                0: rop = 6'b111010;
                1: rop = 6'b110010;
                2: rop = 6'b110011;
                3: rop = 6'b110111;
                default: rop = 6'($urandom);
            endcase
            step($urandom_range(0, 9) < 7, rir, rop, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1, a);
        end

        // Drain
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 6'h0, 1'b1, 1'b0, 1'b0, a);
        chk("drain_empty", q_acc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
